// File: rtl/batcharger_adc_sched.sv
// Round-robin SAR ADC measurement scheduler for the battery V/I/T monitors.
// Optional build macro BATCHARGER_SCHED_AVG_EN: average two back-to-back conversions per measurement.
module batcharger_adc_sched #(
    parameter int unsigned PERIOD  = 256,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       en,
    input  logic       vmonen,
    input  logic       imonen,
    input  logic       tmonen,
    input  logic [7:0] adc_data,
    input  logic       adc_done,
    output logic       adc_start,
    output logic [1:0] adc_sel,
    output logic [7:0] vbat,
    output logic [7:0] ibat,
    output logic [7:0] tbat,
    output logic       vvalid,
    output logic       ivalid,
    output logic       tvalid,
    output logic       busy,
    output logic       tout_err
);
    localparam int unsigned TO_W = 8;
    localparam int unsigned NCH  = 3;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STORE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [TO_W-1:0]  r_to;
    logic [NCH-1:0]   r_pend, r_valid;
    logic [1:0]       r_rr, r_sel;
    logic             r_start, r_busy, r_tout;
    logic [7:0]       r_vbat, r_ibat, r_tbat;

    logic             w_tick, w_gnt_vld, w_done_ok, w_abort, w_release, w_write, w_last;
    logic [NCH-1:0]   w_mon, w_pend_eff, w_sel_oh, w_clr;
    logic [1:0]       w_gnt_sel, w_rr1, w_rr2;
    logic [7:0]       w_result;

    function automatic logic [1:0] f_next(input logic [1:0] ch);
        return (ch >= 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    function automatic logic f_bit(input logic [NCH-1:0] vec, input logic [1:0] ch);
        case (ch)
            2'd0:    return vec[0];
            2'd1:    return vec[1];
            2'd2:    return vec[2];
            default: return 1'b0;
        endcase
    endfunction

    assign w_mon      = {tmonen, imonen, vmonen};
    assign w_tick     = en & (r_cnt == CNT_W'(PERIOD - 1));
    // A tick in the current cycle is visible to the IDLE grant without waiting a cycle
    assign w_pend_eff = r_pend | (w_tick ? w_mon : '0);
    assign w_sel_oh   = NCH'(1) << r_sel;
    assign w_clr      = w_release ? w_sel_oh : '0;
    assign w_rr1      = f_next(r_rr);
    assign w_rr2      = f_next(w_rr1);

`ifdef BATCHARGER_SCHED_AVG_EN
    logic       r_second;
    logic [7:0] r_first;
    assign w_result = 8'((9'(r_first) + 9'(adc_data)) >> 1);
    assign w_last   = r_second;

    // First sample of the pair is held until the second conversion completes
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_second <= 1'b0;
            r_first  <= '0;
        end else if (!en || r_state == S_IDLE) begin
            r_second <= 1'b0;
        end else if (w_done_ok) begin
            r_second <= 1'b1;
            r_first  <= adc_data;
        end
    end
`else
    assign w_result = adc_data;
    assign w_last   = 1'b1;
`endif

    // Round-robin search starting at r_rr
    always_comb begin
        w_gnt_vld = 1'b1;
        w_gnt_sel = r_rr;
        if (f_bit(w_pend_eff, r_rr))       w_gnt_sel = r_rr;
        else if (f_bit(w_pend_eff, w_rr1)) w_gnt_sel = w_rr1;
        else if (f_bit(w_pend_eff, w_rr2)) w_gnt_sel = w_rr2;
        else                               w_gnt_vld = 1'b0;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_ok   = 1'b0;
        w_abort     = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE:  if (w_gnt_vld) w_state_nxt = S_START;
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (adc_done) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = w_last ? S_STORE : S_START;
                end else if (r_to == TO_W'(TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_STORE: begin
                w_release   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!en) w_state_nxt = S_IDLE;
    end

    assign w_write = w_done_ok & w_last;

    // Result registers load on the done edge so data and strobe appear in the STORE cycle
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_cnt   <= '0;
            r_to    <= '0;
            r_pend  <= '0;
            r_rr    <= '0;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
            r_valid <= '0;
            r_vbat  <= '0;
            r_ibat  <= '0;
            r_tbat  <= '0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_to    <= '0;
            r_pend  <= '0;
            r_rr    <= '0;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_tout  <= 1'b0;
            r_valid <= '0;
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + CNT_W'(1);
            r_pend  <= (r_pend & ~w_clr) | (w_tick ? w_mon : '0);
            r_start <= (w_state_nxt == S_START);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_valid <= w_write ? w_sel_oh : '0;
            if (r_state == S_IDLE && w_gnt_vld) r_sel <= w_gnt_sel;
            if (r_state == S_START)     r_to <= '0;
            else if (r_state == S_WAIT) r_to <= r_to + TO_W'(1);
            if (w_release) r_rr <= f_next(r_sel);
            if (w_abort)   r_tout <= 1'b1;
            if (w_write) begin
                case (r_sel)
                    2'd0:    r_vbat <= w_result;
                    2'd1:    r_ibat <= w_result;
                    default: r_tbat <= w_result;
                endcase
            end
        end
    end

    assign adc_start = r_start;
    assign adc_sel   = r_sel;
    assign vbat      = r_vbat;
    assign ibat      = r_ibat;
    assign tbat      = r_tbat;
    assign vvalid    = r_valid[0];
    assign ivalid    = r_valid[1];
    assign tvalid    = r_valid[2];
    assign busy      = r_busy;
    assign tout_err  = r_tout;

endmodule

// File: tb/tb_batcharger_adc_sched.sv
// Scoreboard bench for batcharger_adc_sched: directed scenarios queue expected starts/results,
// a negedge monitor pops and compares them as the DUT produces adc_start and valid strobes.
module tb_batcharger_adc_sched;
    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 64;
`ifdef BATCHARGER_SCHED_AVG_EN
    localparam int CONV = 2;
`else
    localparam int CONV = 1;
`endif

    logic       clk = 1'b0;
    logic       rstz, en, vmonen, imonen, tmonen, adc_done;
    logic [7:0] adc_data;
    logic       adc_start, vvalid, ivalid, tvalid, busy, tout_err;
    logic [1:0] adc_sel;
    logic [7:0] vbat, ibat, tbat;

    batcharger_adc_sched #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rstz(rstz), .en(en),
        .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
        .adc_data(adc_data), .adc_done(adc_done),
        .adc_start(adc_start), .adc_sel(adc_sel),
        .vbat(vbat), .ibat(ibat), .tbat(tbat),
        .vvalid(vvalid), .ivalid(ivalid), .tvalid(tvalid),
        .busy(busy), .tout_err(tout_err)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_start_q[$];
    logic [9:0] exp_res_q[$];
    logic [7:0] base [3];
    bit         mute [3];
    int         lat;

    int cyc = 0, n_starts = 0, last_start = 0, prev_start = 0, tout_cyc = 0;
    int st_cyc [3];
    bit in_flight = 1'b0, tout_q = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [7:0] f_exp(input logic [7:0] b);
`ifdef BATCHARGER_SCHED_AVG_EN
        logic [8:0] s;
        s = {1'b0, b} + {1'b0, b + 8'd3};
        return s[8:1];
`else
        return b;
`endif
    endfunction

    task automatic push_meas(input int ch, input bit ok);
        int n;
        n = ok ? CONV : 1;
        for (int k = 0; k < n; k++) exp_start_q.push_back(ch);
        if (ok) exp_res_q.push_back({2'(ch), f_exp(base[ch])});
    endtask

    task automatic wait_empty(input int budget);
        int k;
        k = 0;
        while ((exp_start_q.size() != 0 || exp_res_q.size() != 0) && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_start_q.size() != 0 || exp_res_q.size() != 0) begin
            n_checks++;
            $display("FAIL wait_empty: %0d starts, %0d results still queued after %0d cycles",
                     exp_start_q.size(), exp_res_q.size(), budget);
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k;
        k = 0;
        while (n_starts < target && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        if (n_starts < target) begin
            n_checks++;
            $display("FAIL wait_starts: saw %0d starts, needed %0d", n_starts, target);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_adc_start"}, int'(adc_start), 0);
        chk({tag, "_adc_sel"}, int'(adc_sel), 0);
        chk({tag, "_vbat"}, int'(vbat), 0);
        chk({tag, "_ibat"}, int'(ibat), 0);
        chk({tag, "_tbat"}, int'(tbat), 0);
        chk({tag, "_valids"}, int'({tvalid, ivalid, vvalid}), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_tout_err"}, int'(tout_err), 0);
    endtask

    task automatic quiesce();
        en = 1'b0; vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0;
        mute[0] = 1'b0; mute[1] = 1'b0; mute[2] = 1'b0;
        lat = 3;
        repeat (2) @(posedge clk);
        #1;
        chk("en_clear_busy", int'(busy), 0);
    endtask

    // ADC model: done 'lat' cycles after the start pulse, second sample of a pair is base+3
    initial begin
        int       cd;
        bit       phase;
        bit [1:0] m_sel;
        cd = 0; phase = 1'b0; m_sel = 2'd0;
        adc_done = 1'b0; adc_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            adc_done = 1'b0;
            if (!rstz || !en) begin
                cd = 0; phase = 1'b0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        adc_done = 1'b1;
                        adc_data = base[m_sel] + (phase ? 8'd3 : 8'd0);
`ifdef BATCHARGER_SCHED_AVG_EN
                        phase = !phase;
`endif
                    end
                end
                if (adc_start && !mute[adc_sel]) begin
                    cd = lat; m_sel = adc_sel;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT starts a conversion or strobes a result
    initial begin
        int         ch;
        logic [7:0] d;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rstz || !en) in_flight = 1'b0;
            if (rstz) begin
                if (adc_start) begin
                    n_starts++;
                    prev_start = last_start;
                    last_start = cyc;
                    st_cyc[adc_sel] = cyc;
                    if (exp_start_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_start: sel=%0d with nothing queued", adc_sel);
                    end else chk("start_sel", int'(adc_sel), exp_start_q.pop_front());
                    chk("busy_at_start", int'(busy), 1);
`ifndef BATCHARGER_SCHED_AVG_EN
                    chk("single_in_flight", int'(in_flight), 0);
`endif
                    in_flight = 1'b1;
                end
                if (vvalid || ivalid || tvalid) begin
                    chk("one_valid", int'(vvalid) + int'(ivalid) + int'(tvalid), 1);
                    ch = vvalid ? 0 : (ivalid ? 1 : 2);
                    d  = vvalid ? vbat : (ivalid ? ibat : tbat);
                    in_flight = 1'b0;
                    if (exp_res_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_valid: ch=%0d data=0x%0h with nothing queued", ch, d);
                    end else begin
                        e = exp_res_q.pop_front();
                        chk("result_ch", ch, int'(e[9:8]));
                        chk("result_data", int'(d), int'(e[7:0]));
                    end
                end
            end
            if (tout_err && !tout_q) begin
                tout_cyc  = cyc;
                in_flight = 1'b0;
            end
            tout_q = tout_err;
        end
    end

    initial begin
        rstz = 1'b0; en = 1'b0; vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0;
        lat = 3;
        for (int i = 0; i < 3; i++) begin base[i] = 8'h00; mute[i] = 1'b0; end
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        #2 rstz = 1'b1;

        // Single voltage monitor: one start every PERIOD cycles, idle between conversions
        @(posedge clk); #1;
        base[0] = 8'h9A; en = 1'b1; vmonen = 1'b1;
        for (int i = 0; i < 3; i++) push_meas(0, 1'b1);
        wait_empty(120);
        chk("v_idle_between", int'(busy), 0);
        chk("v_vbat", int'(vbat), int'(f_exp(8'h9A)));
        chk("v_period", last_start - prev_start, PERIOD);
        quiesce();

        // All three monitors: V, I, T order within one tick
        base[0] = 8'h11; base[1] = 8'h22; base[2] = 8'h33;
        en = 1'b1; vmonen = 1'b1; imonen = 1'b1; tmonen = 1'b1;
        push_meas(0, 1'b1); push_meas(1, 1'b1); push_meas(2, 1'b1);
        wait_empty(80);
        quiesce();
        chk("hold_vbat", int'(vbat), int'(f_exp(8'h11)));
        chk("hold_ibat", int'(ibat), int'(f_exp(8'h22)));
        chk("hold_tbat", int'(tbat), int'(f_exp(8'h33)));

        // Current channel never answers: timeout, sticky error, scheduler moves on to T
        en = 1'b1; vmonen = 1'b1; imonen = 1'b1; tmonen = 1'b1; mute[1] = 1'b1;
        push_meas(0, 1'b1); push_meas(1, 1'b0); push_meas(2, 1'b1);
        wait_starts(n_starts + CONV + 1, 60);
        vmonen = 1'b0; imonen = 1'b0;
        wait_empty(200);
        chk("tout_set", int'(tout_err), 1);
        chk("tout_latency", tout_cyc - st_cyc[1], TIMEOUT + 1);
        chk("tout_ibat_kept", int'(ibat), int'(f_exp(8'h22)));
        quiesce();
        chk("tout_cleared_by_en", int'(tout_err), 0);

        // Reset during WAIT of I (granted after V because of the round-robin pointer)
        base[0] = 8'h44; base[1] = 8'h55;
        en = 1'b1; vmonen = 1'b1;
        push_meas(0, 1'b1);
        wait_empty(60);
        imonen = 1'b1; lat = 20;
        exp_start_q.push_back(1);
        wait_starts(n_starts + 1, 60);
        repeat (3) @(posedge clk);
        #3 rstz = 1'b0;
        #1 check_zero("async_reset");
        lat = 3;
        repeat (3) @(posedge clk);
        #3 rstz = 1'b1;
        push_meas(0, 1'b1); push_meas(1, 1'b1);
        wait_empty(80);
        quiesce();

`ifndef BATCHARGER_SCHED_AVG_EN
        // Latency 14 puts STORE of V exactly on the next tick: V is re-granted immediately
        base[0] = 8'h66; lat = 14;
        en = 1'b1; vmonen = 1'b1;
        push_meas(0, 1'b1); push_meas(0, 1'b1);
        wait_empty(80);
        chk("tick_on_store_regrant", last_start - prev_start, PERIOD + 1);
        quiesce();
`else
        // Averaging: samples 0x10 and 0x13 give 0x11
        base[0] = 8'h10;
        en = 1'b1; vmonen = 1'b1;
        push_meas(0, 1'b1);
        wait_empty(60);
        chk("avg_vbat", int'(vbat), 8'h11);
        quiesce();
`endif

        repeat (20) @(posedge clk);
        #1;
        chk("queues_drained", exp_start_q.size() + exp_res_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
